// File: rtl/pll_sup_pkg.sv
//------------------------------------------------------------------------------
// pll_sup_pkg
//
// Purpose:
//   Shared types and helpers for the PLL lock supervisor. It holds the
//   supervisor state enum and a saturating-increment helper that the event
//   counters use.
//
// Contents:
//   sup_state_e : PLL_RST, WAIT_LOCK, SETTLE, RUN
//   sat_inc()   : increments a value of a given width, holding at all-ones
//------------------------------------------------------------------------------
package pll_sup_pkg;

    // Supervisor states. The two-bit encoding covers all four codes, so the
    // default branch in the FSM exists only as a recovery path.
    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } sup_state_e;

    // Saturating increment for counters up to 32 bits wide. The caller
    // zero-extends its counter into 'value' and truncates the result back.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input int unsigned width);
        logic [31:0] maxVal;
        maxVal = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        if (value >= maxVal) begin
            return maxVal;
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
//------------------------------------------------------------------------------
// sync_2ff
//
// Purpose:
//   Generic two-flop synchronizer. It brings an asynchronous signal into the
//   clk_i domain. The output lags the input by two clk_i edges.
//
// Ports:
//   clk_i   in   destination clock
//   rst_ni  in   asynchronous active-low reset; both stages clear to 0
//   d_i     in   WIDTH  asynchronous input
//   q_o     out  WIDTH  synchronized output
//------------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // The first stage may go metastable. The second stage gives it a full
    // cycle to resolve before any logic sees the value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
//------------------------------------------------------------------------------
// pll_lock_supervisor
//
// Purpose:
//   Supervises an iCE40 SB_PLL40 from the board-oscillator clock domain.
//   - Pulses the PLL's active-low RESETB.
//   - Waits for a synchronized LOCK.
//   - Requires LOCK to stay high for a settle window, then releases the
//     system reset.
//   - Retries the PLL when LOCK does not arrive in time.
//   - Counts lock-loss events seen while running.
//
// Configuration:
//   PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
//     Defined:   lock_loss_count is a saturating counter of RUN-state lock
//                drops.
//     Undefined: the counter is removed and lock_loss_count reads 0.
//
// Ports:
//   clk              in   board oscillator clock, free-running
//   resetn           in   asynchronous active-low reset
//   pll_locked       in   PLL LOCK, asynchronous to clk
//   soft_reset_req   in   single-cycle request to re-reset PLL and system
//   pll_resetb       out  PLL RESETB; low holds the PLL in reset
//   sys_resetn       out  system reset; asserts asynchronously, releases on clk
//   ready            out  high only while in RUN
//   timeout_flag     out  sticky; set on the first lock timeout
//   retry_count      out  EVT_W  saturating count of lock timeouts
//   lock_loss_count  out  EVT_W  saturating count of lock losses in RUN
//------------------------------------------------------------------------------
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 160000,
    parameter int SETTLE_CYCLES       = 1024,
    parameter int CNT_W               = 18,
    parameter int EVT_W               = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pll_locked,
    input  logic             soft_reset_req,
    output logic             pll_resetb,
    output logic             sys_resetn,
    output logic             ready,
    output logic             timeout_flag,
    output logic [EVT_W-1:0] retry_count,
    output logic [EVT_W-1:0] lock_loss_count
);

    // Each state loads the counter with (cycles - 1) on entry and leaves
    // when the counter reaches 0. A state therefore lasts exactly 'cycles'
    // clocks.
    localparam logic [CNT_W-1:0] RstLoad     = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLoad = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SettleLoad  = CNT_W'(SETTLE_CYCLES - 1);

    sup_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [EVT_W-1:0] retry_q, retry_d;
    logic             pll_resetb_q;
    logic             sys_resetn_q;
    logic             ready_q;
    logic             lockSync;

    // LOCK comes from the PLL's own timing, so it is synchronized before
    // any FSM decision uses it.
    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk_i (clk),
        .rst_ni(resetn),
        .d_i   (pll_locked),
        .q_o   (lockSync)
    );

    // Next-state logic. soft_reset_req is checked before any lock test.
    // A request that coincides with a lock drop in RUN therefore re-resets
    // the PLL and is not counted as a lock loss.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        retry_d   = retry_q;

        case (state_q)
            PLL_RST: begin
                if (cnt_q == '0) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TimeoutLoad;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            WAIT_LOCK: begin
                if (soft_reset_req) begin
                    state_d = PLL_RST;
                    cnt_d   = RstLoad;
                end else if (lockSync) begin
                    state_d = SETTLE;
                    cnt_d   = SettleLoad;
                end else if (cnt_q == '0) begin
                    state_d   = PLL_RST;
                    cnt_d     = RstLoad;
                    timeout_d = 1'b1;
                    retry_d   = EVT_W'(sat_inc(32'(retry_q), EVT_W));
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            SETTLE: begin
                if (soft_reset_req) begin
                    state_d = PLL_RST;
                    cnt_d   = RstLoad;
                end else if (!lockSync) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TimeoutLoad;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            RUN: begin
                if (soft_reset_req) begin
                    state_d = PLL_RST;
                    cnt_d   = RstLoad;
                end else if (!lockSync) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TimeoutLoad;
                end
            end

            default: begin
                state_d = PLL_RST;
                cnt_d   = RstLoad;
            end
        endcase
    end

    // State, counter, event registers and the registered outputs. The
    // outputs are decoded from the next state, so each one changes on the
    // same edge as the state it belongs to. They stay glitch-free flop
    // outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= PLL_RST;
            cnt_q        <= RstLoad;
            timeout_q    <= 1'b0;
            retry_q      <= '0;
            pll_resetb_q <= 1'b0;
            sys_resetn_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            retry_q      <= retry_d;
            pll_resetb_q <= (state_d != PLL_RST);
            sys_resetn_q <= (state_d == RUN);
            ready_q      <= (state_d == RUN);
        end
    end

`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
    logic [EVT_W-1:0] loss_q;
    logic             lossEvent;

    // A loss is a lock drop taken while in RUN. It is not a loss when a
    // simultaneous soft reset takes priority.
    assign lossEvent = (state_q == RUN) && !soft_reset_req && !lockSync;

    // Saturating lock-loss counter; cleared only by resetn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            loss_q <= '0;
        end else if (lossEvent) begin
            loss_q <= EVT_W'(sat_inc(32'(loss_q), EVT_W));
        end
    end

    assign lock_loss_count = loss_q;
`else
    assign lock_loss_count = '0;
`endif

    assign pll_resetb   = pll_resetb_q;
    assign sys_resetn   = sys_resetn_q;
    assign ready        = ready_q;
    assign timeout_flag = timeout_q;
    assign retry_count  = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
//------------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Directed bench for pll_lock_supervisor with short cycle parameters
// (PLL reset 4, lock timeout 100, settle 16). Inputs change 1 time unit
// after a rising edge, and outputs are sampled at the same point.
//------------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int P   = 4;
    localparam int T   = 100;
    localparam int S   = 16;
    localparam int LAT = 2 + S + 1;

`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
    localparam int LOSS_ON = 1;
`else
    localparam int LOSS_ON = 0;
`endif

    logic       clk            = 1'b0;
    logic       resetn         = 1'b1;
    logic       pll_locked     = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic       pll_resetb;
    logic       sys_resetn;
    logic       ready;
    logic       timeout_flag;
    logic [7:0] retry_count;
    logic [7:0] lock_loss_count;

    int checks   = 0;
    int failures = 0;
    int expLoss  = 0;

    pll_lock_supervisor #(
        .PLL_RESET_CYCLES   (P),
        .LOCK_TIMEOUT_CYCLES(T),
        .SETTLE_CYCLES      (S),
        .CNT_W              (18),
        .EVT_W              (8)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .pll_resetb     (pll_resetb),
        .sys_resetn     (sys_resetn),
        .ready          (ready),
        .timeout_flag   (timeout_flag),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    // Free-running 100 MHz-style bench clock
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Outputs held at reset values under resetn, then PLL reset pulse width
    task automatic test_reset();
        int n;
        resetn = 1'b1;
        pll_locked = 1'b0;
        soft_reset_req = 1'b0;
        #3;
        resetn = 1'b0;
        tick(3);
        checks++; if (pll_resetb !== 1'b0) begin failures++; $display("[TB] FAIL rst_pll_resetb got=%b exp=0", pll_resetb); end
        checks++; if (sys_resetn !== 1'b0) begin failures++; $display("[TB] FAIL rst_sys_resetn got=%b exp=0", sys_resetn); end
        checks++; if (ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready got=%b exp=0", ready); end
        checks++; if (timeout_flag !== 1'b0) begin failures++; $display("[TB] FAIL rst_timeout got=%b exp=0", timeout_flag); end
        checks++; if (retry_count !== 8'd0) begin failures++; $display("[TB] FAIL rst_retry got=%0d exp=0", retry_count); end
        checks++; if (lock_loss_count !== 8'd0) begin failures++; $display("[TB] FAIL rst_loss got=%0d exp=0", lock_loss_count); end
        resetn = 1'b1;
        n = 0;
        while (pll_resetb !== 1'b1 && n < 20) begin tick(1); n++; end
        checks++; if (n != P) begin failures++; $display("[TB] FAIL rst_pulse_width got=%0d exp=%0d", n, P); end
    endtask

    // Lock arriving at cycle 10 releases the system after sync + settle + 1
    task automatic test_lock_acquire();
        int n;
        tick(10 - P);
        pll_locked = 1'b1;
        n = 0;
        while (sys_resetn !== 1'b1 && n < 60) begin tick(1); n++; end
        checks++; if (n != LAT) begin failures++; $display("[TB] FAIL acq_latency got=%0d exp=%0d", n, LAT); end
        checks++; if (ready !== 1'b1) begin failures++; $display("[TB] FAIL acq_ready got=%b exp=1", ready); end
        checks++; if (pll_resetb !== 1'b1) begin failures++; $display("[TB] FAIL acq_pll_resetb got=%b exp=1", pll_resetb); end
        checks++; if (timeout_flag !== 1'b0) begin failures++; $display("[TB] FAIL acq_timeout got=%b exp=0", timeout_flag); end
        checks++; if (retry_count !== 8'd0) begin failures++; $display("[TB] FAIL acq_retry got=%0d exp=0", retry_count); end
    endtask

    // Lock dropped for 5 cycles while running
    task automatic test_lock_loss();
        int n;
        pll_locked = 1'b0;
        n = 0;
        while (sys_resetn !== 1'b0 && n < 20) begin tick(1); n++; end
        checks++; if (n != 3) begin failures++; $display("[TB] FAIL loss_latency got=%0d exp=3", n); end
        checks++; if (ready !== 1'b0) begin failures++; $display("[TB] FAIL loss_ready got=%b exp=0", ready); end
        tick(2);
        pll_locked = 1'b1;
        n = 0;
        while (sys_resetn !== 1'b1 && n < 60) begin tick(1); n++; end
        checks++; if (n != LAT) begin failures++; $display("[TB] FAIL loss_rerelease got=%0d exp=%0d", n, LAT); end
        expLoss += LOSS_ON;
        checks++; if (lock_loss_count !== 8'(expLoss)) begin failures++; $display("[TB] FAIL loss_count got=%0d exp=%0d", lock_loss_count, expLoss); end
    endtask

    // A 3-cycle glitch mid-settle restarts the full settle window without
    // counting a loss. The drop used to leave RUN does count.
    task automatic test_settle_glitch();
        int n;
        pll_locked = 1'b0;
        tick(4);
        expLoss += LOSS_ON;
        pll_locked = 1'b1;
        tick(8);
        checks++; if (sys_resetn !== 1'b0) begin failures++; $display("[TB] FAIL glitch_sys_in_settle got=%b exp=0", sys_resetn); end
        pll_locked = 1'b0;
        tick(3);
        pll_locked = 1'b1;
        n = 0;
        while (sys_resetn !== 1'b1 && n < 60) begin tick(1); n++; end
        checks++; if (n != LAT) begin failures++; $display("[TB] FAIL glitch_resettle got=%0d exp=%0d", n, LAT); end
        checks++; if (lock_loss_count !== 8'(expLoss)) begin failures++; $display("[TB] FAIL glitch_loss got=%0d exp=%0d", lock_loss_count, expLoss); end
    endtask

    // Soft reset arriving on the same edge as the synchronized lock drop.
    // A second request while in PLL_RST must not stretch the pulse.
    task automatic test_soft_reset();
        pll_locked = 1'b0;
        tick(2);
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        checks++; if (pll_resetb !== 1'b0) begin failures++; $display("[TB] FAIL soft_pll_resetb got=%b exp=0", pll_resetb); end
        checks++; if (sys_resetn !== 1'b0) begin failures++; $display("[TB] FAIL soft_sys_resetn got=%b exp=0", sys_resetn); end
        tick(2);
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        checks++; if (pll_resetb !== 1'b0) begin failures++; $display("[TB] FAIL soft_pulse_mid got=%b exp=0", pll_resetb); end
        tick(1);
        checks++; if (pll_resetb !== 1'b1) begin failures++; $display("[TB] FAIL soft_pulse_end got=%b exp=1", pll_resetb); end
        checks++; if (lock_loss_count !== 8'(expLoss)) begin failures++; $display("[TB] FAIL soft_no_loss got=%0d exp=%0d", lock_loss_count, expLoss); end
    endtask

    // Three lock timeouts with the 104-cycle retry period, then lock
    task automatic test_timeout();
        int n;
        checks++; if (timeout_flag !== 1'b0) begin failures++; $display("[TB] FAIL to_flag_pre got=%b exp=0", timeout_flag); end
        for (int k = 1; k <= 3; k++) begin
            n = 0;
            while (pll_resetb !== 1'b0 && n < 200) begin tick(1); n++; end
            checks++; if (n != T) begin failures++; $display("[TB] FAIL to_wait_%0d got=%0d exp=%0d", k, n, T); end
            checks++; if (retry_count !== 8'(k)) begin failures++; $display("[TB] FAIL to_retry_%0d got=%0d exp=%0d", k, retry_count, k); end
            n = 0;
            while (pll_resetb !== 1'b1 && n < 20) begin tick(1); n++; end
            checks++; if (n != P) begin failures++; $display("[TB] FAIL to_pulse_%0d got=%0d exp=%0d", k, n, P); end
        end
        pll_locked = 1'b1;
        n = 0;
        while (sys_resetn !== 1'b1 && n < 60) begin tick(1); n++; end
        checks++; if (n != LAT) begin failures++; $display("[TB] FAIL to_lock_latency got=%0d exp=%0d", n, LAT); end
        checks++; if (timeout_flag !== 1'b1) begin failures++; $display("[TB] FAIL to_flag_sticky got=%b exp=1", timeout_flag); end
        checks++; if (retry_count !== 8'd3) begin failures++; $display("[TB] FAIL to_retry_final got=%0d exp=3", retry_count); end
    endtask

    // 256 further timeouts push the retry count past its all-ones limit
    task automatic test_saturation();
        pll_locked = 1'b0;
        tick(3 + 256 * (T + P));
        expLoss += LOSS_ON;
        checks++; if (retry_count !== 8'd255) begin failures++; $display("[TB] FAIL sat_retry got=%0d exp=255", retry_count); end
        checks++; if (timeout_flag !== 1'b1) begin failures++; $display("[TB] FAIL sat_flag got=%b exp=1", timeout_flag); end
        checks++; if (pll_resetb !== 1'b1) begin failures++; $display("[TB] FAIL sat_pll_resetb got=%b exp=1", pll_resetb); end
        checks++; if (lock_loss_count !== 8'(expLoss)) begin failures++; $display("[TB] FAIL sat_loss got=%0d exp=%0d", lock_loss_count, expLoss); end
    endtask

    // resetn asserted mid-settle clears everything without waiting for a clock
    task automatic test_reset_mid_settle();
        int n;
        pll_locked = 1'b1;
        tick(6);
        resetn = 1'b0;
        #2;
        checks++; if (pll_resetb !== 1'b0) begin failures++; $display("[TB] FAIL async_pll_resetb got=%b exp=0", pll_resetb); end
        checks++; if (sys_resetn !== 1'b0) begin failures++; $display("[TB] FAIL async_sys_resetn got=%b exp=0", sys_resetn); end
        checks++; if (ready !== 1'b0) begin failures++; $display("[TB] FAIL async_ready got=%b exp=0", ready); end
        checks++; if (timeout_flag !== 1'b0) begin failures++; $display("[TB] FAIL async_timeout got=%b exp=0", timeout_flag); end
        checks++; if (retry_count !== 8'd0) begin failures++; $display("[TB] FAIL async_retry got=%0d exp=0", retry_count); end
        checks++; if (lock_loss_count !== 8'd0) begin failures++; $display("[TB] FAIL async_loss got=%0d exp=0", lock_loss_count); end
        tick(2);
        resetn = 1'b1;
        n = 0;
        while (pll_resetb !== 1'b1 && n < 20) begin tick(1); n++; end
        checks++; if (n != P) begin failures++; $display("[TB] FAIL async_pulse_width got=%0d exp=%0d", n, P); end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_lock_loss();
        test_settle_glitch();
        test_soft_reset();
        test_timeout();
        test_saturation();
        test_reset_mid_settle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Supervises an iCE40 SB_PLL40 from the board-oscillator side.
- Drives the PLL's active-low RESETB and consumes its asynchronous LOCK output.
- Produces a clean, lock-qualified active-low reset for the PLL-generated system domain.
- Retries the PLL on lock timeout and tracks lock-loss events. Sits between the PLL wrapper and the SoC reset controller.

Parameters:
- PLL_RESET_CYCLES, 16: clk cycles RESETB is held low per PLL reset pulse (min 1).
- LOCK_TIMEOUT_CYCLES, 160000: clk cycles allowed in WAIT_LOCK before a retry (10 ms at 16 MHz).
- SETTLE_CYCLES, 1024: consecutive clk cycles synchronized lock must stay high before release.
- CNT_W, 18: width of the shared down-counter; must hold the largest of the three cycle parameters.
- EVT_W, 8: width of the retry and lock-loss counters.

Ports:
- clk  in  1  board oscillator clock (16 MHz), free-running.
- resetn  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL LOCK, asynchronous to clk.
- soft_reset_req  in  1  single-cycle request to re-reset the PLL and system.
- pll_resetb  out  1  to PLL RESETB; low = PLL held in reset.
- sys_resetn  out  1  active-low system reset; asserts asynchronously, releases synchronously to clk.
- ready  out  1  high only in RUN.
- timeout_flag  out  1  sticky; set on the first lock timeout.
- retry_count  out  EVT_W  saturating count of lock timeouts.
- lock_loss_count  out  EVT_W  saturating count of RUN-to-lost-lock events (see Optional Feature).

Behaviour:
- Reset values (resetn low): state=PLL_RST, counter=PLL_RESET_CYCLES-1, pll_resetb=0, sys_resetn=0, ready=0, timeout_flag=0, both counts=0, synchronizer flops=0.
- pll_locked passes through a 2-flop synchronizer to give lock_s. This adds 2 cycles of latency before any state machine decision.
- All outputs are registered. pll_resetb and sys_resetn are driven directly from state-decoded flops.
- PLL_RST:
  - pll_resetb=0, sys_resetn=0; counter decrements.
  - At counter=0: go to WAIT_LOCK and load counter=LOCK_TIMEOUT_CYCLES-1.
- WAIT_LOCK:
  - pll_resetb=1, sys_resetn=0.
  - lock_s=1: go to SETTLE and load counter=SETTLE_CYCLES-1.
  - Else, at counter=0: set timeout_flag, increment retry_count (saturating at all-ones), go to PLL_RST and load PLL_RESET_CYCLES-1.
- SETTLE:
  - sys_resetn=0.
  - lock_s=0: back to WAIT_LOCK with the timeout counter reloaded. Not counted as a loss.
  - lock_s=1 at counter=0: go to RUN.
- RUN:
  - sys_resetn=1, ready=1 on the first RUN cycle.
  - lock_s=0: go to WAIT_LOCK, sys_resetn=0 on the next edge, increment lock_loss_count.
- soft_reset_req in any state except PLL_RST:
  - Go to PLL_RST and reload its counter. It overrides a simultaneous lock_s drop, so there is no loss increment.
  - Ignored while already in PLL_RST; the pulse is not restarted.
- Latency figures:
  - Lock rising to sys_resetn high: 2 (sync) + SETTLE_CYCLES + 1 cycles.
  - Lock falling in RUN to sys_resetn low: 3 cycles.
- Counters saturate and never wrap. timeout_flag clears only on resetn.
- resetn asserted mid-operation immediately forces all reset values, regardless of state.
- Illegal state encodings go to PLL_RST.

Optional Feature:
- Macro: PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN.
- Defined: lock_loss_count is implemented as described above.
- Undefined: the counter register is removed and lock_loss_count is tied to 0. The port is kept so the interface does not change.

Decomposition:
- Shared package pll_sup_pkg holds the state enum (PLL_RST, WAIT_LOCK, SETTLE, RUN) and a saturating-increment function.
- One sub-module, sync_2ff: a generic 2-flop synchronizer with async active-low reset, reused for pll_locked.

Test Plan (PLL_RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, SETTLE_CYCLES=16):
- Release resetn, pll_locked high at cycle 10 → pll_resetb low for exactly 4 cycles; sys_resetn rises 2+16+1=19 cycles after pll_locked rises; ready=1.
- pll_locked held low → pll_resetb pulses low 4 cycles every 104 cycles; retry_count=3 after 3 timeouts; timeout_flag=1 and stays 1 after lock.
- In RUN, drop pll_locked for 5 cycles → sys_resetn low 3 cycles after the drop; lock_loss_count=1; re-release 19 cycles after lock returns. With the macro undefined, the count stays 0.
- Glitch pll_locked low for 3 cycles during SETTLE → returns to WAIT_LOCK; lock_loss_count unchanged; full 16-cycle settle restarts.
- soft_reset_req in RUN coincident with a pll_locked drop → PLL_RST entered; pll_resetb low 4 cycles; no loss increment.
- Force retry_count to 255 via 256+ timeouts (EVT_W=8) → it stays at 255; assert resetn mid-SETTLE → all outputs return to reset values immediately.
